if_id_fetch_stage: RTL and testbench

Fetch stage and IF/ID pipeline register of the 16-bit CPU: owns the program counter, drives the instruction-memory address, and latches the fetched instruction into IF/ID. It is the consumer of the IF/ID flush request (`IF_ID_sync_nop`) and the branch redirect. It replaces flushed slots with a NOP, freezes on hazard stalls, and holds a redirect that arrives during a stall until the stall clears. It also keeps a saturating count of flushed slots for performance debug.

---
 rtl/if_id_fetch_stage.sv | 78 +++++++
 tb/tb_if_id_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, drives the instruction-memory
// address, latches fetched words into IF/ID and holds redirects that arrive during a stall.
module if_id_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_ID_sync_nop,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic [15:0] IF_ID_instr,
    output logic [15:0] IF_ID_pc_plus1,
    output logic        IF_ID_valid,
    output logic [15:0] flush_count
);

    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        pend_valid;
    logic [15:0] pend_pc;

    assign pc_plus1  = pc + 16'd1;
    assign imem_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 16'h0000;
        end else if (redirect_valid && !stall) begin
            // A fresh redirect supersedes any target still waiting from a stall.
            pc         <= redirect_pc;
            pend_valid <= 1'b0;
        end else if (pend_valid && !stall) begin
            pc         <= pend_pc;
            pend_valid <= 1'b0;
        end else if (stall) begin
            if (redirect_valid) begin
                pend_valid <= 1'b1;
                pend_pc    <= redirect_pc;
            end
        end else begin
            pc <= pc_plus1;
        end
    end

    // Flush beats stall: a killed slot must become a NOP even while the pipe is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_pc_plus1 <= 16'h0000;
            IF_ID_valid    <= 1'b0;
        end else if (IF_ID_sync_nop) begin
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_pc_plus1 <= 16'h0000;
            IF_ID_valid    <= 1'b0;
        end else if (!stall) begin
            IF_ID_instr    <= imem_data;
            IF_ID_pc_plus1 <= pc_plus1;
            IF_ID_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_count <= 16'h0000;
        end else if (IF_ID_sync_nop && (flush_count != 16'hFFFF)) begin
            flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage; imem returns 16'h1000 + address.
module tb_if_id_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IF_ID_sync_nop = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] IF_ID_instr;
    logic [15:0] IF_ID_pc_plus1;
    logic        IF_ID_valid;
    logic [15:0] flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .IF_ID_sync_nop (IF_ID_sync_nop),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_data      (imem_data),
        .imem_addr      (imem_addr),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_pc_plus1 (IF_ID_pc_plus1),
        .IF_ID_valid    (IF_ID_valid),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;
    assign imem_data = 16'h1000 + imem_addr;

    // Observation vector: {imem_addr, IF_ID_instr, IF_ID_pc_plus1, IF_ID_valid, flush_count}
    logic [64:0] obs;
    assign obs = {imem_addr, IF_ID_instr, IF_ID_pc_plus1, IF_ID_valid, flush_count};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [64:0] exp;
        #2;
        exp = {16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, exp);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [64:0] exp;
        for (int i = 0; i < 5; i++) begin
            step();
            exp = {16'(i + 1), 16'(16'h1000 + i), 16'(i + 1), 1'b1, 16'h0000};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL seq_fetch_%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_branch_flush();
        logic [64:0] exp;
        // PC = 5 here
        redirect_valid = 1'b1; redirect_pc = 16'h0040; IF_ID_sync_nop = 1'b1;
        step();
        redirect_valid = 1'b0;
        exp = {16'h0040, 16'h0000, 16'h0000, 1'b0, 16'h0001};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL branch_nop1: got %h expected %h", obs, exp);
        end
        step();
        IF_ID_sync_nop = 1'b0;
        exp = {16'h0041, 16'h0000, 16'h0000, 1'b0, 16'h0002};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL branch_nop2: got %h expected %h", obs, exp);
        end
        step();
        exp = {16'h0042, 16'h1041, 16'h0042, 1'b1, 16'h0002};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL branch_resume: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_stall_hold();
        logic [64:0] exp;
        redirect_valid = 1'b1; redirect_pc = 16'h0008;
        step();
        redirect_valid = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = {16'h0008, 16'h1042, 16'h0043, 1'b1, 16'h0002};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, exp);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            exp = {16'(9 + i), 16'(16'h1008 + i), 16'(9 + i), 1'b1, 16'h0002};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stall_resume_%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_redirect_during_stall();
        logic [64:0] exp;
        // PC = 10, IF/ID holds 16'h1009 / 10
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            exp = {16'h000A, 16'h1009, 16'h000A, 1'b1, 16'h0002};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rd_stall_hold_%0d: got %h expected %h", i, obs, exp);
            end
        end
        stall = 1'b0;
        step();
        exp = {16'h0100, 16'h100A, 16'h000B, 1'b1, 16'h0002};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rd_apply: got %h expected %h", obs, exp);
        end
        step();
        step();
        exp = {16'h0102, 16'h1101, 16'h0102, 1'b1, 16'h0002};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rd_pending_empty: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_flush_stall_wrap_sat();
        logic [64:0] exp;
        logic [15:0] exp_count;
        stall = 1'b1; IF_ID_sync_nop = 1'b1;
        step();
        stall = 1'b0; IF_ID_sync_nop = 1'b0;
        exp = {16'h0102, 16'h0000, 16'h0000, 1'b0, 16'h0003};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL flush_beats_stall: got %h expected %h", obs, exp);
        end
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        step();
        exp = {16'h0000, 16'h0FFF, 16'h0000, 1'b1, 16'h0003};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL pc_wrap: got %h expected %h", obs, exp);
        end
        exp_count = 16'h0003;
        IF_ID_sync_nop = 1'b1;
        repeat (16'hFFFE - 16'h0003) begin
            step();
            exp_count = exp_count + 16'd1;
        end
        n_checks++;
        if (flush_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL count_preload: got %h expected %h", flush_count, 16'hFFFE);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (flush_count !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL count_sat_%0d: got %h expected %h", i, flush_count, 16'hFFFF);
            end
        end
        IF_ID_sync_nop = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [64:0] exp;
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0200;
        step();
        redirect_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp = {16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs, exp);
        end
        step();
        @(negedge clk);
        stall = 1'b0;
        rst = 1'b0;
        step();
        exp = {16'h0001, 16'h1000, 16'h0001, 1'b1, 16'h0000};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_no_pending: got %h expected %h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_flush();
        test_stall_hold();
        test_redirect_during_stall();
        test_flush_stall_wrap_sat();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
